// File: rtl/gray_codec_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// gray_codec_pipe
//   Two-stage pipelined binary<->Gray converter with valid/ready handshake.
//   Each word carries its own mode bit:
//     0 = binary->Gray
//     1 = Gray->binary
//   Each result also reports whether its Gray-domain value is exactly one bit
//   away from the Gray value of the previous result.
//
//   Stage 1 captures the raw word and mode. The conversion and the adjacency
//   test run on the S1->S2 path, and stage 2 holds the result shown on out_*.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     upstream word valid
//   in_ready     block accepts a word this cycle (0 while rst=1)
//   in_mode      0: binary->Gray, 1: Gray->binary
//   in_data      word to convert (WIDTH bits)
//   out_valid    result valid
//   out_ready    downstream accepts result
//   out_data     converted word (WIDTH bits)
//   out_mode     mode the result was produced with
//   out_adjacent Gray value differs from previous result's Gray value in 1 bit
// ---------------------------------------------------------------------------
module gray_codec_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_adjacent
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Stage 1: raw input word
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic             s1_mode_q;

  // Stage 2: converted result
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_data_q;
  logic             s2_mode_q;
  logic             s2_adj_q;

  // Gray value of the most recent result, used for the adjacency test
  logic [WIDTH-1:0] prev_gray_q;
  logic             prev_seen_q;

  logic             s2_free;
  logic             in_fire;
  logic             s1_move;

  logic [WIDTH-1:0] gray_of_bin;
  logic [WIDTH-1:0] bin_of_gray;
  logic [WIDTH-1:0] gray_d;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] gray_diff;
  logic             adj_d;

  // Handshake
  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !rst && (!s1_valid_q || s2_free);
  assign in_fire  = in_valid && in_ready;
  assign s1_move  = s1_valid_q && s2_free;

  // Binary->Gray
  assign gray_of_bin = s1_data_q ^ (s1_data_q >> 1);

  // Gray->binary: each binary bit is the XOR of all Gray bits at or above it.
  // Expressing it as a slice reduction avoids a bit-to-bit ripple through one
  // vector and keeps every bit an independent XOR tree.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bin
      assign bin_of_gray[gi] = ^s1_data_q[WIDTH-1:gi];
    end
  endgenerate

  // Gray-domain view of the word:
  //   mode 1 -> the input word is already Gray
  //   mode 0 -> use the computed Gray value
  assign gray_d   = s1_mode_q ? s1_data_q : gray_of_bin;
  assign result_d = s1_mode_q ? bin_of_gray : gray_of_bin;

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero
  assign gray_diff = gray_d ^ prev_gray_q;
  assign adj_d     = prev_seen_q && (gray_diff != '0)
                     && ((gray_diff & (gray_diff - ONE)) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_mode_q   <= 1'b0;
      s2_adj_q    <= 1'b0;
      prev_gray_q <= '0;
      prev_seen_q <= 1'b0;
    end else begin
      // S1 may drain into S2 and refill from upstream on the same edge
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= in_data;
        s1_mode_q  <= in_mode;
      end else if (s1_move) begin
        s1_valid_q <= 1'b0;
      end

      if (s1_move) begin
        s2_valid_q  <= 1'b1;
        s2_data_q   <= result_d;
        s2_mode_q   <= s1_mode_q;
        s2_adj_q    <= adj_d;
        prev_gray_q <= gray_d;
        prev_seen_q <= 1'b1;
      end else if (out_ready) begin
        // Result consumed and nothing behind it. Data fields keep their last
        // value; only the valid bit drops.
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_mode     = s2_mode_q;
  assign out_adjacent = s2_adj_q;

endmodule

// File: tb/tb_gray_codec_pipe.sv
`timescale 1ns/1ps
// Testbench for gray_codec_pipe: a WIDTH=4 and a WIDTH=8 instance sharing
// clock and reset.
module tb_gray_codec_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       v4_in_valid, v4_in_ready, v4_in_mode;
  logic       v4_out_valid, v4_out_ready, v4_out_mode, v4_out_adj;
  logic [3:0] v4_in_data, v4_out_data;

  logic       v8_in_valid, v8_in_ready, v8_in_mode;
  logic       v8_out_valid, v8_out_ready, v8_out_mode, v8_out_adj;
  logic [7:0] v8_in_data, v8_out_data;

  gray_codec_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(v4_in_valid), .in_ready(v4_in_ready), .in_mode(v4_in_mode), .in_data(v4_in_data),
    .out_valid(v4_out_valid), .out_ready(v4_out_ready), .out_data(v4_out_data),
    .out_mode(v4_out_mode), .out_adjacent(v4_out_adj)
  );

  gray_codec_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_mode(v8_in_mode), .in_data(v8_in_data),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out_data(v8_out_data),
    .out_mode(v8_out_mode), .out_adjacent(v8_out_adj)
  );

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic       mode;
    logic [3:0] din;
    logic [3:0] dout;
    logic       adj;
  } vec4_t;

  typedef struct {
    logic [7:0] d;
    logic       m;
    logic       a;
  } exp_t;

  exp_t       q4[$];
  exp_t       q8[$];
  logic [7:0] st_d4[$];
  logic       st_m4[$];
  logic [7:0] st_d8[$];
  logic       st_m8[$];
  logic [7:0] prev4, prev8;
  bit         seen4, seen8;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: Gray and its inverse written as shift/XOR folds
  function automatic logic [7:0] m_gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] m_bin(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int s = 1; s < 8; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic queue4(input logic [3:0] d, input logic m);
    exp_t       e;
    logic [7:0] g;
    g   = m ? {4'h0, d} : m_gray({4'h0, d});
    e.d = m ? m_bin({4'h0, d}) : g;
    e.m = m;
    e.a = seen4 && ($countones(g ^ prev4) == 1);
    prev4 = g;
    seen4 = 1'b1;
    q4.push_back(e);
    st_d4.push_back({4'h0, d});
    st_m4.push_back(m);
  endtask

  task automatic queue8(input logic [7:0] d, input logic m);
    exp_t       e;
    logic [7:0] g;
    g   = m ? d : m_gray(d);
    e.d = m ? m_bin(d) : g;
    e.m = m;
    e.a = seen8 && ($countones(g ^ prev8) == 1);
    prev8 = g;
    seen8 = 1'b1;
    q8.push_back(e);
    st_d8.push_back(d);
    st_m8.push_back(m);
  endtask

  // Asserts reset between edges, checks reset state, releases, and ends
  // 1 ns after a rising edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    seen4 = 1'b0;
    prev4 = '0;
    seen8 = 1'b0;
    prev8 = '0;
    q4.delete();
    q8.delete();
    #1;
    chk("rst_in_ready4",  v4_in_ready,  0);
    chk("rst_out_valid4", v4_out_valid, 0);
    chk("rst_out_data4",  v4_out_data,  0);
    chk("rst_out_mode4",  v4_out_mode,  0);
    chk("rst_out_adj4",   v4_out_adj,   0);
    chk("rst_out_valid8", v8_out_valid, 0);
    chk("rst_in_ready8",  v8_in_ready,  0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rel_in_ready4", v4_in_ready, 1);
    chk("rel_in_ready8", v8_in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // Streams st_*4 into dut4 back to back. If stall_len > 0, out_ready is
  // held low for stall_len cycles starting at the first visible output.
  task automatic run4(input int stall_len, input int max_cyc, output int cycles);
    int         idx, cyc, stall_left, n;
    bit         stalled_once, have_held;
    logic [3:0] held_d;
    logic       held_m, held_a;
    exp_t       e;

    idx = 0;
    cyc = 0;
    stall_left = 0;
    stalled_once = 0;
    have_held = 0;
    n = st_d4.size();

    while ((idx < n || q4.size() > 0) && cyc < max_cyc) begin
      v4_in_valid = (idx < n);
      v4_in_data  = (idx < n) ? st_d4[idx][3:0] : 4'h0;
      v4_in_mode  = (idx < n) ? st_m4[idx] : 1'b0;
      if (v4_out_valid && !stalled_once && stall_len > 0) begin
        stalled_once = 1;
        stall_left   = stall_len;
      end
      v4_out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        chk("bp_in_ready", v4_in_ready, 0);
        if (have_held) begin
          chk("bp_hold_data", v4_out_data, held_d);
          chk("bp_hold_mode", v4_out_mode, held_m);
          chk("bp_hold_adj",  v4_out_adj,  held_a);
        end else begin
          held_d = v4_out_data;
          held_m = v4_out_mode;
          held_a = v4_out_adj;
          have_held = 1;
        end
        stall_left--;
      end
      if (v4_out_valid && v4_out_ready) begin
        if (q4.size() == 0) begin
          total++;
          $display("FAIL extra_out4: got %0h, expected no output", v4_out_data);
        end else begin
          e = q4.pop_front();
          chk("s4_data", v4_out_data, e.d);
          chk("s4_mode", v4_out_mode, e.m);
          chk("s4_adj",  v4_out_adj,  e.a);
          $display("out4 data=%h mode=%0d adj=%0d", v4_out_data, v4_out_mode, v4_out_adj);
        end
      end
      if (v4_in_valid && v4_in_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end

    cycles = cyc;
    v4_in_valid  = 1'b0;
    v4_out_ready = 1'b1;
    chk("sent4",  idx, n);
    chk("drain4", q4.size(), 0);
    st_d4.delete();
    st_m4.delete();
    q4.delete();
  endtask

  // Streams st_*8 into dut8 with random valid/ready on both sides.
  task automatic run8(input int max_cyc);
    int   idx, cyc, n;
    exp_t e;

    idx = 0;
    cyc = 0;
    n = st_d8.size();

    while ((idx < n || q8.size() > 0) && cyc < max_cyc) begin
      v8_in_valid  = (idx < n) && ($urandom_range(0, 3) != 0);
      v8_in_data   = (idx < n) ? st_d8[idx] : 8'h00;
      v8_in_mode   = (idx < n) ? st_m8[idx] : 1'b0;
      v8_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (v8_out_valid && v8_out_ready) begin
        if (q8.size() == 0) begin
          total++;
          $display("FAIL extra_out8: got %0h, expected no output", v8_out_data);
        end else begin
          e = q8.pop_front();
          chk("s8_data", v8_out_data, e.d);
          chk("s8_mode", v8_out_mode, e.m);
          chk("s8_adj",  v8_out_adj,  e.a);
          $display("out8 data=%h mode=%0d adj=%0d", v8_out_data, v8_out_mode, v8_out_adj);
        end
      end
      if (v8_in_valid && v8_in_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end

    v8_in_valid  = 1'b0;
    v8_out_ready = 1'b1;
    chk("sent8",  idx, n);
    chk("drain8", q8.size(), 0);
  endtask

  // One isolated WIDTH=8 transaction with hand-supplied expectations
  task automatic single8(input logic m, input logic [7:0] d, input logic [7:0] ed, input logic ea);
    v8_in_valid  = 1'b1;
    v8_in_mode   = m;
    v8_in_data   = d;
    v8_out_ready = 1'b1;
    @(posedge clk);
    #1;
    v8_in_valid = 1'b0;
    chk("w8_latency", v8_out_valid, 0);
    @(posedge clk);
    #1;
    chk("w8_valid", v8_out_valid, 1);
    chk("w8_data",  v8_out_data,  ed);
    chk("w8_mode",  v8_out_mode,  m);
    chk("w8_adj",   v8_out_adj,   ea);
    $display("out8 data=%h mode=%0d adj=%0d", v8_out_data, v8_out_mode, v8_out_adj);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec4_t tbl[6];
    int    cycles;

    // Hand-computed single transactions; adjacency follows from the row
    // before it (first row after reset is never adjacent).
    tbl[0] = '{mode: 1'b0, din: 4'b1011, dout: 4'b1110, adj: 1'b0};
    tbl[1] = '{mode: 1'b1, din: 4'b1110, dout: 4'b1011, adj: 1'b0};  // same Gray value
    tbl[2] = '{mode: 1'b0, din: 4'b0101, dout: 4'b0111, adj: 1'b0};  // 1110 -> 0111
    tbl[3] = '{mode: 1'b1, din: 4'b0110, dout: 4'b0100, adj: 1'b1};  // 0111 -> 0110
    tbl[4] = '{mode: 1'b0, din: 4'b0100, dout: 4'b0110, adj: 1'b0};  // same Gray value
    tbl[5] = '{mode: 1'b0, din: 4'b0011, dout: 4'b0010, adj: 1'b1};  // 0110 -> 0010

    rst          = 1'b1;
    v4_in_valid  = 1'b0;
    v4_in_mode   = 1'b0;
    v4_in_data   = '0;
    v4_out_ready = 1'b1;
    v8_in_valid  = 1'b0;
    v8_in_mode   = 1'b0;
    v8_in_data   = '0;
    v8_out_ready = 1'b1;
    @(posedge clk);
    do_reset();

    // Isolated single transactions from the table
    for (int i = 0; i < 6; i++) begin
      v4_in_valid  = 1'b1;
      v4_in_mode   = tbl[i].mode;
      v4_in_data   = tbl[i].din;
      v4_out_ready = 1'b1;
      #1;
      chk("t_in_ready", v4_in_ready, 1);
      @(posedge clk);
      #1;
      v4_in_valid = 1'b0;
      v4_in_data  = 4'h0;
      chk("t_latency", v4_out_valid, 0);
      @(posedge clk);
      #1;
      chk("t_valid", v4_out_valid, 1);
      chk("t_data",  v4_out_data,  tbl[i].dout);
      chk("t_mode",  v4_out_mode,  tbl[i].mode);
      chk("t_adj",   v4_out_adj,   tbl[i].adj);
      $display("out4 data=%h mode=%0d adj=%0d", v4_out_data, v4_out_mode, v4_out_adj);
      @(posedge clk);
      #1;
      chk("t_drained", v4_out_valid, 0);
    end

    // Back-to-back 0..15 then 0: 17 results in 19 cycles, all adjacent except the first
    do_reset();
    for (int i = 0; i < 16; i++) queue4(4'(i), 1'b0);
    queue4(4'h0, 1'b0);
    run4(0, 100, cycles);
    chk("stream_cycles", cycles, 19);

    // Backpressure: out_ready low for 6 cycles after the first output
    queue4(4'b0111, 1'b0);
    queue4(4'b0101, 1'b1);
    queue4(4'b1111, 1'b0);
    queue4(4'b0000, 1'b1);
    queue4(4'b1000, 1'b0);
    run4(6, 100, cycles);

    // Reset with both stages full
    do_reset();
    v4_out_ready = 1'b0;
    v4_in_valid  = 1'b1;
    v4_in_mode   = 1'b0;
    v4_in_data   = 4'b0001;
    @(posedge clk);
    #1;
    v4_in_data = 4'b0010;
    @(posedge clk);
    #1;
    v4_in_valid = 1'b0;
    chk("full_out_valid", v4_out_valid, 1);
    chk("full_in_ready",  v4_in_ready,  0);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", v4_out_valid, 0);
    chk("async_out_data",  v4_out_data,  0);
    chk("async_in_ready",  v4_in_ready,  0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", v4_in_ready, 1);
    seen4 = 1'b0;
    prev4 = '0;
    v4_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no_stale_out", v4_out_valid, 0);
    end

    // Gray 0000 is one bit from the pre-reset 0001, but reset cleared history
    queue4(4'b0000, 1'b0);
    run4(0, 20, cycles);

    // WIDTH=8
    single8(1'b0, 8'hFF, 8'h80, 1'b0);
    single8(1'b1, 8'h80, 8'hFF, 1'b0);
    prev8 = 8'h80;
    seen8 = 1'b1;
    for (int i = 0; i < 40; i++) queue8(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++)  queue8(8'(i + 100), 1'b0);  // consecutive binary -> adjacent
    run8(1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
